// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB-first through one full-subtractor cell
// and a borrow flop, returning a (WIDTH+1)-bit two's-complement difference.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   d,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic x, y, diff, borrow_nxt;

    // Full-subtractor cell on the current LSBs
    assign x          = ra_q[0];
    assign y          = rb_q[0];
    assign diff       = x ^ y ^ borrow_q;
    assign borrow_nxt = (~x & y) | (~(x ^ y) & borrow_q);

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ra_d     = a;
                    rb_d     = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                ra_d     = ra_q >> 1;
                rb_d     = rb_q >> 1;
                // Each new bit enters at the MSB; after WIDTH shifts bit i lands at i
                res_d    = {diff, res_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ra_q     <= '0;
            rb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign d         = {borrow_q, res_q};

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor, the inverse counterpart of the team's ripple-carry serial adder. It accepts two WIDTH-bit unsigned operands over a valid/ready handshake and computes a - b LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flop. It returns a (WIDTH+1)-bit result over a second valid/ready handshake. It sits in the arithmetic datapath wherever area matters more than throughput.

Parameters:
WIDTH, 4, operand width in bits; legal range is 2 or more.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b are valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend, unsigned
b  input  WIDTH  subtrahend, unsigned
out_valid  output  1  result d is valid
out_ready  input  1  consumer accepts d
d  output  WIDTH+1  difference; d[WIDTH] is the final borrow (1 when a<b); d is a - b as (WIDTH+1)-bit two's complement
busy  output  1  high in RUN or DONE

Behaviour:
- Reset is asynchronous and active-low, one clock domain.
- While rst_n=0:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - d=0
  - internal operand, result and borrow registers=0, bit counter=0
- Reset asserted mid-operation aborts the operation immediately. No partial result is ever presented.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, capture a into shift register ra and b into rb, clear borrow and counter, then go to RUN.
  - With in_valid=0, stay in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each edge processes bit i = counter, with x=ra[0], y=rb[0], br=borrow:
    - diff = x^y^br
    - borrow_next = (~x & y) | (~(x^y) & br)
  - ra and rb shift right by 1. diff shifts into the MSB of the WIDTH-bit result register, so after WIDTH edges bit i sits at position i.
  - Counter increments each edge. On the edge processing bit WIDTH-1, go to DONE.
- DONE:
  - out_valid=1, d={borrow, result}.
  - d and out_valid are held stable until out_ready=1 on an edge. On that edge go to IDLE and clear out_valid.
  - d keeps its last value after the handshake (consumers must ignore it while out_valid=0).
- Latency:
  - Accept on edge E0, then bits on edges E1..EWIDTH.
  - out_valid is first high after edge EWIDTH, i.e. WIDTH cycles after accept.
  - Minimum issue interval is WIDTH+2 cycles with out_ready tied high.
- No overlap: in_ready=0 in RUN and DONE, so a new operand cannot be accepted on the same edge that completes the output handshake. in_valid in those states is ignored and has no side effects.
- in_valid is allowed to drop without acceptance; the source obeys the standard valid/ready rule.
- Arithmetic: d = (a - b) mod 2^(WIDTH+1).
  - The final borrow equals the unsigned comparison a<b.
  - No saturation, no overflow flag.
- Counter width is clog2(WIDTH)+1. It never wraps during an operation.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> in_ready=1, out_valid=0, busy=0, d=0. Release; first accept is processed correctly.
- Basic, WIDTH=4: a=5, b=3, out_ready=1 -> out_valid rises exactly 4 cycles after accept, d=5'b00010.
- Negative and boundaries:
  - a=3, b=5 -> d=5'b11110 (-2)
  - a=0, b=15 -> d=5'b10001
  - a=15, b=15 -> d=0
  - a=15, b=0 -> d=5'b01111
- Output backpressure: a=9, b=4, out_ready=0 for 6 cycles -> d=5'b00101 stable and out_valid held the whole time. Raising out_ready gives IDLE next cycle. in_valid pulsed during the stall is not accepted.
- Mid-op reset: accept a=12, b=7, assert rst_n=0 after 2 RUN cycles -> outputs at reset values asynchronously. Next operation a=1, b=2 -> d=5'b11111, with no residue from the aborted operation.
- Exhaustive / back-to-back: WIDTH=4, all 256 a/b pairs, out_ready randomised -> every d matches the (a-b) mod 32 model. Accept spacing is never below 6 cycles. Repeat random 10k vectors at WIDTH=8 and WIDTH=2.
